// File: rtl/cpu_ext_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ext_pkg
// Shared definitions for the immediate-extension logic. The ID-stage extender
// and the EX-stage forwarding path both use these.
//   ext_mode_t  : 2-bit extension-mode selector (SIGN / ZERO / UPPER / BRANCH)
//   IMM_W_DEF   : default raw immediate width
//   DATA_W_DEF  : default extended datapath width
// -----------------------------------------------------------------------------
package cpu_ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_t;

    localparam int IMM_W_DEF  = 16;
    localparam int DATA_W_DEF = 32;

endpackage : cpu_ext_pkg

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extender. It can be reused anywhere an
// immediate has to be widened, for example in the EX-stage forwarding path.
//   imm_in   [IMM_W-1:0]  raw immediate field
//   ext_mode ext_mode_t   SIGN / ZERO / UPPER (LUI form) / BRANCH (SIGN << 2)
//   ext_out  [DATA_W-1:0] extended value
// -----------------------------------------------------------------------------
module imm_ext_core
    import cpu_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [IMM_W-1:0]  imm_in,
    input  ext_mode_t         ext_mode,
    output logic [DATA_W-1:0] ext_out
);

    localparam int PAD_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] sign_val;
    logic [DATA_W-1:0] zero_val;
    logic [DATA_W-1:0] upper_val;

    assign sign_val  = {{PAD_W{imm_in[IMM_W-1]}}, imm_in};
    assign zero_val  = {{PAD_W{1'b0}}, imm_in};
    assign upper_val = {imm_in, {PAD_W{1'b0}}};

    // NOTE: every output of a combinational block gets a default before the
    // case statement. A path that leaves it unassigned would infer a latch.
    always_comb begin
        ext_out = sign_val;
        unique case (ext_mode)
            EXT_SIGN:   ext_out = sign_val;
            EXT_ZERO:   ext_out = zero_val;
            EXT_UPPER:  ext_out = upper_val;
            // Branch offsets are word-aligned. Bits shifted past the top are dropped.
            EXT_BRANCH: ext_out = sign_val << 2;
            default:    ext_out = sign_val;
        endcase
    end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
// Immediate extender with a 1- or 2-deep registered output. It sits between
// the ID-stage decoder and the ID/EX boundary. Stall and Flush act on every
// stage, so hazard logic treats this path like any other ID/EX field.
// Each edge applies one action. The priority order is
// Reset > Flush > Stall > advance.
//   Clk             clock, rising edge
//   Reset           asynchronous, active-high; clears every stage
//   Imm_in          raw immediate from the decoder
//   ExtMode         extension mode (cpu_ext_pkg::ext_mode_t)
//   Valid_in        Imm_in/ExtMode are meaningful this cycle
//   Stall           hold every stage
//   Flush           clear every stage (valid=0, data=0); wins over Stall
//   ExtensionResult extended immediate from the final stage (registered)
//   Valid_out       ExtensionResult is meaningful (registered)
// -----------------------------------------------------------------------------
module imm_ext_pipe
    import cpu_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STAGES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [IMM_W-1:0]  Imm_in,
    input  ext_mode_t         ExtMode,
    input  logic              Valid_in,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] ExtensionResult,
    output logic              Valid_out
);

    // Reject illegal configurations at elaboration time.
    if (IMM_W < 1 || IMM_W > DATA_W - 2) begin : g_bad_width
        $error("imm_ext_pipe: IMM_W must satisfy 1 <= IMM_W <= DATA_W-2");
    end
    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("imm_ext_pipe: STAGES must be 1 or 2");
    end

    logic [DATA_W-1:0] ext_val;

    imm_ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .imm_in   (Imm_in),
        .ext_mode (ExtMode),
        .ext_out  (ext_val)
    );

    // Stage 1: always present.
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then sample their inputs at the same edge, whatever the block order.
    // Data is captured even when Valid_in=0. Its value is don't-care then,
    // and capturing it unconditionally avoids an extra enable term.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else if (Flush) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else if (!Stall) begin
            s1_data  <= ext_val;
            s1_valid <= Valid_in;
        end
    end

    if (STAGES == 2) begin : g_two_stage
        logic [DATA_W-1:0] s2_data;
        logic              s2_valid;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else if (Flush) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else if (!Stall) begin
                s2_data  <= s1_data;
                s2_valid <= s1_valid;
            end
        end

        assign ExtensionResult = s2_data;
        assign Valid_out       = s2_valid;
    end else begin : g_one_stage
        assign ExtensionResult = s1_data;
        assign Valid_out       = s1_valid;
    end

endmodule : imm_ext_pipe

// File: tb/tb_imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_pipe
// Directed test of imm_ext_pipe in three configurations:
//   u_s1 : defaults, STAGES=1
//   u_s2 : defaults, STAGES=2
//   u_w  : IMM_W=12, DATA_W=24, STAGES=1
// All instances share the control inputs. Inputs change 1 time unit after the
// rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_imm_ext_pipe;
    import cpu_ext_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [15:0] imm;
    logic [11:0] imm_w;
    ext_mode_t   mode;
    logic        valid_in;
    logic        stall;
    logic        flush;

    logic [31:0] res_s1;
    logic        vld_s1;
    logic [31:0] res_s2;
    logic        vld_s2;
    logic [23:0] res_w;
    logic        vld_w;

    int n_cmp = 0;
    int n_err = 0;

    imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .STAGES(1)) u_s1 (
        .Clk(Clk), .Reset(Reset), .Imm_in(imm), .ExtMode(mode),
        .Valid_in(valid_in), .Stall(stall), .Flush(flush),
        .ExtensionResult(res_s1), .Valid_out(vld_s1)
    );

    imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .STAGES(2)) u_s2 (
        .Clk(Clk), .Reset(Reset), .Imm_in(imm), .ExtMode(mode),
        .Valid_in(valid_in), .Stall(stall), .Flush(flush),
        .ExtensionResult(res_s2), .Valid_out(vld_s2)
    );

    imm_ext_pipe #(.IMM_W(12), .DATA_W(24), .STAGES(1)) u_w (
        .Clk(Clk), .Reset(Reset), .Imm_in(imm_w), .ExtMode(mode),
        .Valid_in(valid_in), .Stall(stall), .Flush(flush),
        .ExtensionResult(res_w), .Valid_out(vld_w)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset is asserted from time 0. It is asynchronous, so no edge is needed.
        n_cmp++; if (res_s1 !== 32'h0) begin n_err++; $display("FAIL por_res_s1 got %h want %h", res_s1, 32'h0); end
        n_cmp++; if (vld_s1 !== 1'b0)  begin n_err++; $display("FAIL por_vld_s1 got %b want 0", vld_s1); end
        n_cmp++; if (res_s2 !== 32'h0) begin n_err++; $display("FAIL por_res_s2 got %h want %h", res_s2, 32'h0); end
        n_cmp++; if (vld_s2 !== 1'b0)  begin n_err++; $display("FAIL por_vld_s2 got %b want 0", vld_s2); end
        Reset = 1'b0;
        // Put data in flight, then assert Reset between edges.
        imm = 16'h8004; mode = EXT_SIGN; valid_in = 1'b1;
        step();
        step();
        n_cmp++; if (vld_s2 !== 1'b1) begin n_err++; $display("FAIL inflight_vld_s2 got %b want 1", vld_s2); end
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (res_s1 !== 32'h0) begin n_err++; $display("FAIL midrst_res_s1 got %h want %h", res_s1, 32'h0); end
        n_cmp++; if (vld_s1 !== 1'b0)  begin n_err++; $display("FAIL midrst_vld_s1 got %b want 0", vld_s1); end
        n_cmp++; if (res_s2 !== 32'h0) begin n_err++; $display("FAIL midrst_res_s2 got %h want %h", res_s2, 32'h0); end
        n_cmp++; if (vld_s2 !== 1'b0)  begin n_err++; $display("FAIL midrst_vld_s2 got %b want 0", vld_s2); end
        valid_in = 1'b0;
        #1 Reset = 1'b0;
    endtask

    task automatic test_modes();
        ext_mode_t   modes [4] = '{EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH};
        logic [31:0] exp   [4] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010};
        for (int i = 0; i < 4; i++) begin
            imm = 16'h8004; mode = modes[i]; valid_in = 1'b1;
            step();
            n_cmp++; if (res_s1 !== exp[i]) begin n_err++; $display("FAIL mode%0d_res got %h want %h", i, res_s1, exp[i]); end
            n_cmp++; if (vld_s1 !== 1'b1)   begin n_err++; $display("FAIL mode%0d_vld got %b want 1", i, vld_s1); end
        end
        valid_in = 1'b0;
        step();
        n_cmp++; if (vld_s1 !== 1'b0) begin n_err++; $display("FAIL mode_drain_vld got %b want 0", vld_s1); end
    endtask

    task automatic test_back_to_back();
        // Drain u_s2 first.
        valid_in = 1'b0;
        step(); step();
        imm = 16'h0001; mode = EXT_SIGN; valid_in = 1'b1;
        step();                                   // cycle 1
        n_cmp++; if (vld_s2 !== 1'b0) begin n_err++; $display("FAIL b2b_c1_vld got %b want 0", vld_s2); end
        imm = 16'hFFFF; mode = EXT_ZERO; valid_in = 1'b1;
        step();                                   // cycle 2
        n_cmp++; if (res_s2 !== 32'h00000001) begin n_err++; $display("FAIL b2b_c2_res got %h want %h", res_s2, 32'h00000001); end
        n_cmp++; if (vld_s2 !== 1'b1)         begin n_err++; $display("FAIL b2b_c2_vld got %b want 1", vld_s2); end
        valid_in = 1'b0;
        step();                                   // cycle 3
        n_cmp++; if (res_s2 !== 32'h0000FFFF) begin n_err++; $display("FAIL b2b_c3_res got %h want %h", res_s2, 32'h0000FFFF); end
        n_cmp++; if (vld_s2 !== 1'b1)         begin n_err++; $display("FAIL b2b_c3_vld got %b want 1", vld_s2); end
        step();                                   // cycle 4
        n_cmp++; if (vld_s2 !== 1'b0) begin n_err++; $display("FAIL b2b_c4_vld got %b want 0", vld_s2); end
    endtask

    task automatic test_stall();
        imm = 16'h0010; mode = EXT_SIGN; valid_in = 1'b1;       // entry A
        step();
        imm = 16'h1234; mode = EXT_ZERO; valid_in = 1'b1;       // entry B
        step();
        n_cmp++; if (res_s2 !== 32'h00000010) begin n_err++; $display("FAIL stall_pre_res got %h want %h", res_s2, 32'h00000010); end
        // These inputs are presented during the stall and must not be captured.
        stall = 1'b1; imm = 16'hBEEF; mode = EXT_UPPER; valid_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (res_s2 !== 32'h00000010) begin n_err++; $display("FAIL stall%0d_res_s2 got %h want %h", c, res_s2, 32'h00000010); end
            n_cmp++; if (vld_s2 !== 1'b1)         begin n_err++; $display("FAIL stall%0d_vld_s2 got %b want 1", c, vld_s2); end
            n_cmp++; if (res_s1 !== 32'h00001234) begin n_err++; $display("FAIL stall%0d_res_s1 got %h want %h", c, res_s1, 32'h00001234); end
        end
        stall = 1'b0; valid_in = 1'b0;
        step();
        n_cmp++; if (res_s2 !== 32'h00001234) begin n_err++; $display("FAIL stall_post_res got %h want %h", res_s2, 32'h00001234); end
        n_cmp++; if (vld_s2 !== 1'b1)         begin n_err++; $display("FAIL stall_post_vld got %b want 1", vld_s2); end
        step();
        n_cmp++; if (vld_s2 !== 1'b0) begin n_err++; $display("FAIL stall_drain_vld got %b want 0", vld_s2); end
    endtask

    task automatic test_flush_stall();
        imm = 16'h0003; mode = EXT_SIGN; valid_in = 1'b1;
        step();
        imm = 16'h0004; mode = EXT_SIGN; valid_in = 1'b1;
        step();
        n_cmp++; if (vld_s2 !== 1'b1) begin n_err++; $display("FAIL flush_pre_vld got %b want 1", vld_s2); end
        flush = 1'b1; stall = 1'b1; imm = 16'h7777; valid_in = 1'b1;
        step();
        n_cmp++; if (res_s2 !== 32'h0) begin n_err++; $display("FAIL flush_res_s2 got %h want %h", res_s2, 32'h0); end
        n_cmp++; if (vld_s2 !== 1'b0)  begin n_err++; $display("FAIL flush_vld_s2 got %b want 0", vld_s2); end
        n_cmp++; if (res_s1 !== 32'h0) begin n_err++; $display("FAIL flush_res_s1 got %h want %h", res_s1, 32'h0); end
        n_cmp++; if (vld_s1 !== 1'b0)  begin n_err++; $display("FAIL flush_vld_s1 got %b want 0", vld_s1); end
        flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
        step();
        // Stage 2 now holds the cleared stage-1 contents.
        n_cmp++; if (res_s2 !== 32'h0) begin n_err++; $display("FAIL flush_after1_res got %h want %h", res_s2, 32'h0); end
        n_cmp++; if (vld_s2 !== 1'b0)  begin n_err++; $display("FAIL flush_after1_vld got %b want 0", vld_s2); end
        step();
        n_cmp++; if (vld_s2 !== 1'b0) begin n_err++; $display("FAIL flush_after2_vld got %b want 0", vld_s2); end
    endtask

    task automatic test_width();
        ext_mode_t   modes [4] = '{EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH};
        logic [23:0] exp   [4] = '{24'hFFFFFF, 24'h000FFF, 24'hFFF000, 24'hFFFFFC};
        for (int i = 0; i < 4; i++) begin
            imm_w = 12'hFFF; mode = modes[i]; valid_in = 1'b1;
            step();
            n_cmp++; if (res_w !== exp[i]) begin n_err++; $display("FAIL width_mode%0d_res got %h want %h", i, res_w, exp[i]); end
            n_cmp++; if (vld_w !== 1'b1)   begin n_err++; $display("FAIL width_mode%0d_vld got %b want 1", i, vld_w); end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        imm      = '0;
        imm_w    = '0;
        mode     = EXT_SIGN;
        valid_in = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        #2;
        test_reset();
        test_modes();
        test_back_to_back();
        test_stall();
        test_flush_stall();
        test_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_imm_ext_pipe
